// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/DIV unit holding the architectural HI/LO registers.
// Define MULTDIV_UNSIGNED_EN to enable MULTU/DIVU (Op[1]=1); undefined, every op is signed.
module mult_div_unit #(
  parameter int ITER = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state_q, state_d;

  logic [2*DATA_W-1:0] acc;
  logic [DATA_W:0]     rem;
  logic [DATA_W-1:0]   opb;
  logic [CNT_W-1:0]    cnt;
  logic                is_div;
  logic                neg_lo;
  logic                neg_hi;
  logic                sgn_in;
  logic                sgn_q;
  logic                accept;
  logic                last_iter;
  logic                wr_ok;
  logic                b_zero;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W+1:0]   div_trial;
  logic [2*DATA_W-1:0] prod_fix;
  logic                unused_bits;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

`ifdef MULTDIV_UNSIGNED_EN
  assign sgn_in = ~Op[1];
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       sgn_q <= 1'b0;
    else if (accept) sgn_q <= sgn_in;
  end
  assign unused_bits = rem[DATA_W];
`else
  assign sgn_in      = 1'b1;
  assign sgn_q       = 1'b1;
  assign unused_bits = rem[DATA_W] ^ Op[1];
`endif

  assign b_zero    = (B == '0);
  assign wr_ok     = (state_q == IDLE) || (state_q == DONE);
  assign last_iter = (cnt == CNT_W'(ITER - 1));
  assign Busy      = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign Done      = (state_q == DONE);

  // Shift-add: acc[31:0] holds the remaining multiplier bits, acc[63:32] the running sum.
  assign mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? opb : '0)};
  // Restoring divide: acc[31:0] shifts the dividend out and the quotient in.
  assign div_shift = {rem[DATA_W-1:0], acc[DATA_W-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, opb};
  assign prod_fix  = neg64(acc, sgn_q & neg_lo);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Start) begin
          accept = 1'b1;
          if (!Op[0])      state_d = MUL;
          else if (b_zero) state_d = DONE;
          else             state_d = DIV;
        end
      end
      MUL:     if (last_iter) state_d = FIX;
      DIV:     if (last_iter) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc     <= '0;
      rem     <= '0;
      opb     <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      if (accept) begin
        cnt     <= '0;
        rem     <= '0;
        is_div  <= Op[0];
        neg_lo  <= A[DATA_W-1] ^ B[DATA_W-1];
        neg_hi  <= A[DATA_W-1];
        DivZero <= Op[0] & b_zero;
        if (Op[0]) begin
          acc <= {{DATA_W{1'b0}}, magnitude(A, sgn_in)};
          opb <= magnitude(B, sgn_in);
        end else begin
          acc <= {{DATA_W{1'b0}}, magnitude(B, sgn_in)};
          opb <= magnitude(A, sgn_in);
        end
      end else if (state_q == MUL) begin
        acc <= {mul_sum, acc[DATA_W-1:1]};
        cnt <= cnt + CNT_W'(1);
      end else if (state_q == DIV) begin
        if (!div_trial[DATA_W+1]) begin
          rem               <= div_trial[DATA_W:0];
          acc[DATA_W-1:0]   <= {acc[DATA_W-2:0], 1'b1};
        end else begin
          rem               <= div_shift;
          acc[DATA_W-1:0]   <= {acc[DATA_W-2:0], 1'b0};
        end
        cnt <= cnt + CNT_W'(1);
      end else if (state_q == FIX) begin
        // Remainder takes the dividend's sign so quotient truncates toward zero.
        if (is_div) begin
          Lo <= neg32(acc[DATA_W-1:0], sgn_q & neg_lo);
          Hi <= neg32(rem[DATA_W-1:0], sgn_q & neg_hi);
        end else begin
          Hi <= prod_fix[2*DATA_W-1:DATA_W];
          Lo <= prod_fix[DATA_W-1:0];
        end
      end
      if (wr_ok && HiWrite) Hi <= WriteData;
      if (wr_ok && LoWrite) Lo <= WriteData;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: scoreboard of expected HI/LO, latency and busy time.
module tb_mult_div_unit;
  localparam int ITER = 32;

  logic        Clk = 1'b0;
  logic        Reset, Start, HiWrite, LoWrite;
  logic [1:0]  Op;
  logic [31:0] A, B, WriteData;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  typedef struct {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
    int          t0;
    int          lat;
    int          busy;
  } ent_t;

  ent_t        sb[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  mult_div_unit #(.ITER(ITER)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic              uns;
    logic signed [63:0] sa, sb_, q, m;
    logic [63:0]       r;
`ifdef MULTDIV_UNSIGNED_EN
    uns = op[1];
`else
    uns = 1'b0;
`endif
    sa = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    if (!op[0]) begin
      if (uns) r = {32'd0, a} * {32'd0, b};
      else     r = sa * sb_;
    end else begin
      if (uns) r = {a % b, a / b};
      else begin
        q = sa / sb_;
        m = sa % sb_;
        r = {m[31:0], q[31:0]};
      end
    end
    return r;
  endfunction

  task automatic service();
    ent_t e;
    if (Reset) busy_cnt = 0;
    else if (Done) begin
      if (sb.size() == 0) chk("unexp_done", {31'b0, Done}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("hi", Hi, e.hi);
        chk("lo", Lo, e.lo);
        chk("divzero", {31'b0, DivZero}, {31'b0, e.dz});
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
      end
      busy_cnt = 0;
    end else if (Busy) busy_cnt++;
  endtask

  task automatic tick();
    @(negedge Clk);
    cyc++;
    service();
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    ent_t        e;
    logic [63:0] r;
    e.dz = op[0] && (b == 32'd0);
    if (e.dz) begin
      e.hi = mdl_hi; e.lo = mdl_lo; e.lat = 1; e.busy = 0;
    end else begin
      r = model(op, a, b);
      e.hi = r[63:32]; e.lo = r[31:0]; e.lat = ITER + 2; e.busy = ITER + 1;
      mdl_hi = e.hi; mdl_lo = e.lo;
    end
    e.t0 = cyc;
    sb.push_back(e);
    Start = 1'b1; Op = op; A = a; B = b;
    tick();
    Start = 1'b0;
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
    HiWrite = hw; LoWrite = lw; WriteData = d;
    if (hw) mdl_hi = d;
    if (lw) mdl_lo = d;
    tick();
    HiWrite = 1'b0; LoWrite = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!Done && n < budget) begin
      tick();
      n++;
    end
    if (!Done) chk("wait_done", {31'b0, Done}, 32'd1);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb, prev_hi;
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
    tick(); tick();
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_dz", {31'b0, DivZero}, 32'd0);
    Reset = 1'b0;
    tick();

    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    chk("busy_e0", {31'b0, Busy}, 32'd1);
    drain(60);
    chk("mult_hi", Hi, 32'hFFFF_FFFF);
    chk("mult_lo", Lo, 32'hFFFF_FFEB);

    issue(2'b01, 32'hFFFF_FFF9, 32'd2);
    drain(60);
    chk("div_lo", Lo, 32'hFFFF_FFFD);
    chk("div_hi", Hi, 32'hFFFF_FFFF);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    drain(60);
    chk("ovf_lo", Lo, 32'h8000_0000);
    chk("ovf_hi", Hi, 32'd0);
    issue(2'b01, 32'd7, 32'hFFFF_FFFE);
    drain(60);

    mt(1'b1, 1'b0, 32'h0000_1234);
    chk("mthi", Hi, 32'h0000_1234);
    mt(1'b0, 1'b1, 32'h0000_5678);
    chk("mtlo", Lo, 32'h0000_5678);
    issue(2'b01, 32'd5, 32'd0);
    drain(10);
    chk("dz_hi", Hi, 32'h0000_1234);
    chk("dz_lo", Lo, 32'h0000_5678);
    tick(); tick(); tick();
    chk("dz_hold", {31'b0, DivZero}, 32'd1);
    issue(2'b00, 32'd3, 32'd5);
    chk("dz_clear", {31'b0, DivZero}, 32'd0);
    drain(60);

    HiWrite = 1'b1; WriteData = 32'hAAAA_5555; mdl_hi = 32'hAAAA_5555;
    issue(2'b01, 32'd9, 32'd0);
    HiWrite = 1'b0;
    drain(10);
    chk("wr_with_start", Hi, 32'hAAAA_5555);

    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain(60);
`ifdef MULTDIV_UNSIGNED_EN
    chk("multu_hi", Hi, 32'hFFFF_FFFE);
    chk("multu_lo", Lo, 32'h0000_0001);
`else
    chk("multu_hi", Hi, 32'h0000_0000);
    chk("multu_lo", Lo, 32'h0000_0001);
`endif

    prev_hi = mdl_hi;
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    repeat (8) tick();
    Start = 1'b1; Op = 2'b01; A = 32'd100; B = 32'd3;
    HiWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
    tick();
    Start = 1'b0; HiWrite = 1'b0;
    chk("hi_busy", Hi, prev_hi);
    chk("busy_mid", {31'b0, Busy}, 32'd1);
    drain(60);
    chk("ign_hi", Hi, 32'hFFFF_FFFF);
    chk("ign_lo", Lo, 32'hFFFF_FFEB);

    issue(2'b00, 32'd12345, 32'hFFFF_0000);
    wait_done(60);
    issue(2'b11, 32'hFFFF_FFF0, 32'd7);
    drain(60);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i == 2) rb = $urandom_range(1, 15);
      if (i == 5) rb = 32'd0;
      issue(rop, ra, rb);
      drain(60);
    end

    mt(1'b1, 1'b1, 32'hCAFE_F00D);
    issue(2'b01, 32'h7FFF_FFFF, 32'd3);
    repeat (19) tick();
    Reset = 1'b1;
    #1;
    chk("abort_hi", Hi, 32'd0);
    chk("abort_lo", Lo, 32'd0);
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_done", {31'b0, Done}, 32'd0);
    sb.delete();
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    tick();
    Reset = 1'b0;
    repeat (40) tick();
    chk("abort_hold_hi", Hi, 32'd0);
    chk("abort_hold_lo", Lo, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
